// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package irq_pkg;

    localparam int unsigned NSRC_DEF    = 8;
    localparam int unsigned HOLDOFF_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_e;

    // Index width for n sources; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/acknowledge handshake between the interrupt controller and the core.
interface irq_ctrl_if #(
    parameter int unsigned NSRC = irq_pkg::NSRC_DEF
) ();
    import irq_pkg::*;

    localparam int unsigned IDW = id_width(NSRC);

    logic           ExtIRQ;
    logic           ExtIAck;
    logic [IDW-1:0] irq_id;

    modport master (output ExtIRQ, output irq_id, input ExtIAck);
    modport slave  (input ExtIRQ, input irq_id, output ExtIAck);

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over a request vector.
module irq_prio_enc #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            valid_c,
    output logic [IDW-1:0]  idx_c
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) idx_c = IDW'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: edge capture, pending/overflow tracking,
// priority selection and the 4-phase ExtIRQ/ExtIAck handshake with holdoff.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NSRC    = NSRC_DEF,
    parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            clr_ovf,
    irq_ctrl_if.master      bus,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] ovf
);

    localparam int unsigned IDW = id_width(NSRC);
    localparam int unsigned HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    irq_state_e      state_q, state_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] rise_c;
    logic [NSRC-1:0] cand_c;
    logic [NSRC-1:0] clr_c;
    logic [HW-1:0]   hold_q, hold_d;
    logic            ext_irq_q, ext_irq_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            serve_c;
    logic            win_valid_c;
    logic [IDW-1:0]  win_id_c;

    assign rise_c = irq_src & ~src_q;
    assign cand_c = pending & ~irq_mask;
    assign clr_c  = serve_c ? (NSRC'(1) << id_q) : '0;

    assign bus.ExtIRQ = ext_irq_q;
    assign bus.irq_id = id_q;

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio (
        .req     (cand_c),
        .valid_c (win_valid_c),
        .idx_c   (win_id_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hold_q == '0 && win_valid_c) state_d = REQ;
            REQ:     if (bus.ExtIAck)                 state_d = ACK;
            ACK:     if (!bus.ExtIAck)                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, holdoff counter and served-clear strobe.
    always_comb begin
        ext_irq_d = 1'b0;
        id_d      = id_q;
        hold_d    = hold_q;
        serve_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (win_valid_c) begin
                    ext_irq_d = 1'b1;
                    id_d      = win_id_c;
                end
            end
            REQ: begin
                ext_irq_d = !bus.ExtIAck;
                serve_c   = bus.ExtIAck;
            end
            ACK: begin
                if (!bus.ExtIAck) hold_d = HW'(HOLDOFF);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_irq_q <= 1'b0;
            id_q      <= '0;
            hold_q    <= '0;
        end else begin
            ext_irq_q <= ext_irq_d;
            id_q      <= id_d;
            hold_q    <= hold_d;
        end
    end

    // A new edge always wins over both the handshake clear and clr_ovf.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q   <= '0;
            pending <= '0;
            ovf     <= '0;
        end else begin
            src_q   <= irq_src;
            pending <= rise_c | (pending & ~clr_c);
            ovf     <= (rise_c & pending & ~clr_c) | (clr_ovf ? '0 : ovf);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: vector table, directed handshake corners, then random traffic vs. a reference model.
module tb_irq_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned HO = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] src   = '0;
    logic [N-1:0] mask  = '0;
    logic         ack   = 1'b0;
    logic         clr   = 1'b0;
    logic [N-1:0] pend;
    logic [N-1:0] ovf;
    logic         ack_prev = 1'b0;
    bit           allow_proto = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    irq_ctrl_if #(.NSRC(N)) bus ();
    assign bus.ExtIAck = ack;

    irq_ctrl #(.NSRC(N), .HOLDOFF(HO)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (src),
        .irq_mask (mask),
        .clr_ovf  (clr),
        .bus      (bus),
        .pending  (pend),
        .ovf      (ovf)
    );

    typedef struct {
        logic [7:0] src;
        logic [7:0] mask;
        logic       ack;
        logic       clr;
        logic       irq;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] ovf;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [7:0] s, input logic [7:0] m, input logic a, input logic c,
                                input logic i, input logic [2:0] d, input logic [7:0] p, input logic [7:0] o);
        vec_t v;
        v.src = s; v.mask = m; v.ack = a; v.clr = c;
        v.irq = i; v.id = d; v.pend = p; v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_irq(input int exp_id, input int maxc);
        bit got;
        got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            tick();
            got = bus.ExtIRQ;
        end
        chk("wait_irq", 32'(got), 32'd1);
        if (got) chk("wait_irq_id", 32'(bus.irq_id), 32'(exp_id));
    endtask

    // Core must only raise ExtIAck in answer to a live request.
    always @(posedge clk) begin
        if (reset && ack && !ack_prev && !allow_proto) begin
            checks++;
            if (!bus.ExtIRQ) begin
                errors++;
                $display("FAIL proto ExtIAck rose while ExtIRQ=0 t=%0t", $time);
            end
        end
        ack_prev <= ack;
    end

    // Reference model: per-source event bookkeeping plus a request/ack/holdoff phase tracker.
    logic [N-1:0] m_pend, m_ovf, m_prev;
    bit           m_req, m_ackph;
    int           m_hold, m_id;

    function automatic void m_reset();
        m_pend = '0; m_ovf = '0; m_prev = '0;
        m_req = 1'b0; m_ackph = 1'b0; m_hold = 0; m_id = 0;
    endfunction

    function automatic void m_step(input logic [N-1:0] s, input logic [N-1:0] mk_v, input logic a, input logic c);
        int win, served;
        bit ev, setov;
        win = -1;
        served = -1;
        for (int i = 0; i < int'(N); i++) if (win < 0 && m_pend[i] && !mk_v[i]) win = i;
        if (m_req) begin
            if (a) begin served = m_id; m_req = 1'b0; m_ackph = 1'b1; end
        end else if (m_ackph) begin
            if (!a) begin m_ackph = 1'b0; m_hold = HO; end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (win >= 0) begin
            m_req = 1'b1; m_id = win;
        end
        for (int i = 0; i < int'(N); i++) begin
            ev    = s[i] && !m_prev[i];
            setov = ev && m_pend[i] && (i != served);
            if (setov)  m_ovf[i] = 1'b1;
            else if (c) m_ovf[i] = 1'b0;
            if (ev)                m_pend[i] = 1'b1;
            else if (i == served)  m_pend[i] = 1'b0;
            m_prev[i] = s[i];
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 8'h00);
        tbl[1]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00);
        tbl[2]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 8'h00);
        tbl[3]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00);
        tbl[4]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00);
        tbl[5]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00);
        tbl[6]  = mk(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 8'h00);
        tbl[7]  = mk(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 8'h00);
        tbl[8]  = mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 8'h00);
        tbl[9]  = mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 8'h00);
        tbl[10] = mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 8'h00);
        tbl[11] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00);
        tbl[12] = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        tbl[13] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

        idle(2);
        chk("rst_irq", 32'(bus.ExtIRQ), 32'd0);
        chk("rst_id", 32'(bus.irq_id), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            src = tbl[i].src; mask = tbl[i].mask; ack = tbl[i].ack; clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_irq", i), 32'(bus.ExtIRQ), 32'(tbl[i].irq));
            chk($sformatf("tbl%0d_id", i), 32'(bus.irq_id), 32'(tbl[i].id));
            chk($sformatf("tbl%0d_pend", i), 32'(pend), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
        end

        // Simultaneous edges on 5 and 2, then exact holdoff spacing.
        idle(5);
        src = 8'h24; tick(); chk("dual_pend", 32'(pend), 32'h24);
        src = 8'h00; tick(); chk("dual_irq", 32'(bus.ExtIRQ), 32'd1); chk("dual_id2", 32'(bus.irq_id), 32'd2);
        ack = 1'b1;  tick(); chk("dual_drop", 32'(bus.ExtIRQ), 32'd0); chk("dual_pend2", 32'(pend), 32'h20);
        ack = 1'b0;  tick();
        for (int k = 0; k < int'(HO); k++) begin
            tick(); chk($sformatf("holdoff%0d", k), 32'(bus.ExtIRQ), 32'd0);
        end
        tick(); chk("dual_irq5", 32'(bus.ExtIRQ), 32'd1); chk("dual_id5", 32'(bus.irq_id), 32'd5);
        ack = 1'b1; tick(); chk("dual_pend0", 32'(pend), 32'h00);
        ack = 1'b0; tick();

        // Overflow on bit 6, edge coinciding with the clear, clr_ovf precedence.
        idle(5);
        src = 8'h40; tick(); chk("ov_pend", 32'(pend), 32'h40);
        src = 8'h00; tick(); chk("ov_id", 32'(bus.irq_id), 32'd6);
        src = 8'h40; tick(); chk("ov_set", 32'(ovf), 32'h40); chk("ov_irq", 32'(bus.ExtIRQ), 32'd1);
        src = 8'h00; clr = 1'b1; tick(); chk("ov_clr", 32'(ovf), 32'h00);
        clr = 1'b0; src = 8'h40; ack = 1'b1; tick();
        chk("ov_coinc_pend", 32'(pend), 32'h40); chk("ov_coinc_ovf", 32'(ovf), 32'h00);
        chk("ov_coinc_irq", 32'(bus.ExtIRQ), 32'd0);
        ack = 1'b0; src = 8'h00; tick();
        src = 8'h40; clr = 1'b1; tick(); chk("ov_setwins", 32'(ovf), 32'h40);
        tick(); chk("ov_clr2", 32'(ovf), 32'h00);
        src = 8'h00; clr = 1'b0;
        wait_irq(6, 8);
        ack = 1'b1; tick(); chk("ov_served", 32'(pend), 32'h00);
        ack = 1'b0; tick();

        // Request on 4 is not retargeted by a new event on 1 or by masking 4.
        idle(5);
        src = 8'h10; tick();
        src = 8'h00; tick(); chk("ret_id4", 32'(bus.irq_id), 32'd4);
        src = 8'h02; mask = 8'h10; tick();
        chk("ret_irq", 32'(bus.ExtIRQ), 32'd1); chk("ret_id", 32'(bus.irq_id), 32'd4); chk("ret_pend", 32'(pend), 32'h12);
        src = 8'h00; tick(); chk("ret_hold", 32'(bus.irq_id), 32'd4);
        ack = 1'b1; tick(); chk("ret_pend2", 32'(pend), 32'h02);
        ack = 1'b0; mask = 8'h00; tick();
        wait_irq(1, 8);
        ack = 1'b1; tick();
        ack = 1'b0; tick();

        // Stray acknowledge while idle is ignored.
        mask = 8'hff; src = 8'h01; allow_proto = 1'b1; tick();
        src = 8'h00; ack = 1'b1; tick();
        chk("stray_pend", 32'(pend), 32'h01); chk("stray_irq", 32'(bus.ExtIRQ), 32'd0);
        ack = 1'b0; tick();
        allow_proto = 1'b0; mask = 8'h00;
        wait_irq(0, 8);

        // Asynchronous reset mid-request, line held high across release.
        #2; reset = 1'b0; src = 8'h80;
        #1;
        chk("arst_irq", 32'(bus.ExtIRQ), 32'd0); chk("arst_pend", 32'(pend), 32'h00); chk("arst_ovf", 32'(ovf), 32'h00);
        reset = 1'b1;
        tick(); chk("arst_edge", 32'(pend), 32'h80); chk("arst_irq0", 32'(bus.ExtIRQ), 32'd0);
        tick(); chk("arst_irq1", 32'(bus.ExtIRQ), 32'd1); chk("arst_id7", 32'(bus.irq_id), 32'd7);
        ack = 1'b1; tick();
        ack = 1'b0; tick();

        // Random traffic against the reference model.
        reset = 1'b0; src = '0; mask = '0; clr = 1'b0; ack = 1'b0;
        tick();
        reset = 1'b1;
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            m_step(src, mask, ack, clr);
            tick();
            chk("rnd_irq", 32'(bus.ExtIRQ), 32'(m_req));
            chk("rnd_pend", 32'(pend), 32'(m_pend));
            chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
            if (m_req || m_ackph) chk("rnd_id", 32'(bus.irq_id), 32'(m_id));
            src = src ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 31) == 0) mask = N'($urandom & $urandom);
            clr = ($urandom_range(0, 15) == 0);
            if (bus.ExtIRQ && !ack && $urandom_range(0, 2) == 0) ack = 1'b1;
            else if (!bus.ExtIRQ && ack && $urandom_range(0, 1) == 0) ack = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
